player_sprite_plotter: RTL and testbench
========================================

Name: player_sprite_plotter

Overview:
- Downstream stage of the player position/colour register; consumes its top-left x/y and colour outputs.
- On a start pulse, latches the sprite origin and colour, then sweeps a WIDTH x HEIGHT box one pixel per clock.
- Emits VGA-adapter write strobes (x, y, colour, plot) and finishes with a one-cycle done pulse.
- Erasing is the same sweep with colour 3'b000; the block does not treat black specially.

Parameters:
WIDTH, 12, sprite width in pixels (even, 2..16)
HEIGHT, 8, sprite height in pixels (1..16)
XMAX, 160, screen width; pixels with x >= XMAX are clipped
YMAX, 120, screen height; pixels with y >= YMAX are clipped

Ports:
clock  input  1  main circuit clock
reset  input  1  synchronous, active-low reset
start  input  1  single-cycle request to draw; sampled only in IDLE
x_in  input  8  sprite top-left x
y_in  input  7  sprite top-left y
color_in  input  3  sprite colour
x_out  output  8  pixel x to VGA adapter
y_out  output  7  pixel y to VGA adapter
color_out  output  3  pixel colour to VGA adapter
plot  output  1  write-enable for current pixel
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last pixel

Behaviour:
- All outputs are registered.
- Reset (clock edge with reset=0):
  - state=IDLE, cx=cy=0.
  - x_out=0, y_out=0, color_out=0, plot=0, busy=0, done=0.
  - Reset overrides everything, including mid-sweep: the sweep is abandoned, no further plot, no done.
- States: IDLE, DRAW, DONE.
- IDLE:
  - plot=0, busy=0, done=0.
  - On start=1: latch bx=x_in, by=y_in, bc=color_in; cx=cy=0; go to DRAW.
  - start in any other state is ignored; it is not queued.
- DRAW (one pixel per clock):
  - x_out <= bx+cx, y_out <= by+cy, color_out <= bc.
  - plot <= 1 iff visible (see clipping).
  - cx increments; when cx==WIDTH-1, cx wraps to 0 and cy increments.
  - After pixel (WIDTH-1, HEIGHT-1) is issued, go to DONE.
  - Raster order: row-major, left to right, top to bottom.
- DONE: plot=0, done=1 for exactly one cycle, busy=0, then IDLE.
- Latency (start sampled at edge t):
  - busy=1 and pixel 0 on outputs after edge t+1.
  - Pixel k on outputs after edge t+1+k.
  - Last pixel after edge t+WIDTH*HEIGHT.
  - done=1 after edge t+WIDTH*HEIGHT+1.
  - Earliest next accepted start is at edge t+WIDTH*HEIGHT+2.
- Arithmetic and clipping:
  - Sums bx+cx and by+cy are computed at 9 bits / 8 bits, without truncation.
  - visible = (bx+cx < XMAX) and (by+cy < YMAX).
  - x_out/y_out carry the truncated sums; when not visible, plot=0.
  - A fully off-screen sprite still takes the full sweep time and still pulses done.
- Input changes: x_in/y_in/color_in changes during DRAW have no effect; the latched values are used.
- Counter sizing: counters are sized for the maximum parameter values and never exceed WIDTH-1 or HEIGHT-1.

Optional Feature:
Macro: PLAYER_SHIP_MASK_EN
- Defined: plot additionally requires (cx+cy >= WIDTH/2-1) and (cx <= cy+WIDTH/2), giving a ship/triangle outline.
  - With defaults, rows 0..7 plot 2,4,6,8,10,12,12,12 pixels (66 total).
  - Timing is unchanged (still WIDTH*HEIGHT cycles).
- Undefined: full rectangle; every visible pixel plots.

Test Plan:
- Reset: hold reset=0 for 2 clocks -> all outputs 0, state IDLE; start=1 while reset=0 -> no busy.
- Basic draw: start with x_in=14, y_in=99, color_in=111 ->
  - busy rises next cycle.
  - 96 plot pulses, first pixel (14,99), 12th (25,99), last (25,106), all colour 111.
  - done exactly 97 cycles after start; busy low with done.
- Clipping: start x_in=154, y_in=115 -> 6 columns x 5 rows = 30 plot pulses; done still at cycle 97; x=250 -> 0 plot pulses, done at cycle 97.
- Busy/ignored start: start at cycle 0 and again at cycle 40 with different x_in=94 -> single sweep at original origin, one done; start held at done cycle -> ignored; start one cycle after done -> accepted.
- Reset mid-operation: reset=0 at pixel 50 of a sweep -> next cycle plot=0, busy=0, no done; fresh start afterwards -> complete 96-pixel sweep.
- PLAYER_SHIP_MASK_EN defined, origin (54,99) colour 111 -> 66 plot pulses, row 0 plots only x=59,60, rows 5..7 plot x=54..65, done at cycle 97.

Source files
------------

// File: rtl/player_sprite_plotter.sv
// rtl/player_sprite_plotter.sv - sweeps a WIDTH x HEIGHT sprite box into VGA-adapter pixel writes
// Optional PLAYER_SHIP_MASK_EN restricts plotting to a ship/triangle outline.
module player_sprite_plotter #(
    parameter int WIDTH  = 12,
    parameter int HEIGHT = 8,
    parameter int XMAX   = 160,
    parameter int YMAX   = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] color_in,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] color_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [3:0] CX_LAST = 4'(WIDTH - 1);
    localparam logic [3:0] CY_LAST = 4'(HEIGHT - 1);
    localparam logic [8:0] X_LIMIT = 9'(XMAX);
    localparam logic [7:0] Y_LIMIT = 8'(YMAX);

    state_t     state;
    logic [3:0] cx, cy;
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] bc;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       visible;
    logic       shape_ok;

    // Sums keep their carry so sprites hanging off the right/bottom edge clip instead of wrapping.
    assign sum_x   = {1'b0, bx} + {5'b0, cx};
    assign sum_y   = {1'b0, by} + {4'b0, cy};
    assign visible = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);

`ifdef PLAYER_SHIP_MASK_EN
    localparam logic [4:0] HALF = 5'(WIDTH / 2);
    logic [4:0] diag;
    assign diag     = {1'b0, cx} + {1'b0, cy};
    assign shape_ok = (diag >= HALF - 5'd1) && ({1'b0, cx} <= {1'b0, cy} + HALF);
`else
    assign shape_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cx        <= '0;
            cy        <= '0;
            bx        <= '0;
            by        <= '0;
            bc        <= '0;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        bx    <= x_in;
                        by    <= y_in;
                        bc    <= color_in;
                        cx    <= '0;
                        cy    <= '0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    x_out     <= sum_x[7:0];
                    y_out     <= sum_y[6:0];
                    color_out <= bc;
                    plot      <= visible && shape_ok;
                    busy      <= 1'b1;
                    if (cx == CX_LAST) begin
                        cx <= '0;
                        if (cy == CY_LAST) begin
                            state <= DONE;
                        end else begin
                            cy <= cy + 4'd1;
                        end
                    end else begin
                        cx <= cx + 4'd1;
                    end
                end
                DONE: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_player_sprite_plotter.sv
// tb/tb_player_sprite_plotter.sv - self-checking bench for player_sprite_plotter
module tb_player_sprite_plotter;
    localparam int W = 12;
    localparam int H = 8;
    localparam int XM = 160;
    localparam int YM = 120;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [2:0] color_in = '0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] color_out;
    logic       plot, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x, y, c;
        int plots;
        int fx, fy, lx, ly;
    } vec_t;
    vec_t vecs[5];

    player_sprite_plotter #(.WIDTH(W), .HEIGHT(H), .XMAX(XM), .YMAX(YM)) dut (
        .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .color_in(color_in), .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: which box offsets should light up, from screen bounds and the outline rule.
    function automatic bit model_plot(input int col, input int row, input int ox, input int oy);
        bit v;
        v = (ox + col < XM) && (oy + row < YM);
`ifdef PLAYER_SHIP_MASK_EN
        v = v && (col + row >= W / 2 - 1) && (col <= row + W / 2);
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sweep(input int x, input int y, input int c, input bit noise,
                         output int nplot, output int fx, output int fy,
                         output int lx, output int ly);
        int bad, exp_plots, ex, ey, col, row;
        logic [7:0] exl;
        logic [6:0] eyl;
        bit vis;
        bad = 0; nplot = 0; exp_plots = 0;
        fx = -1; fy = -1; lx = -1; ly = -1;
        start = 1'b1; x_in = 8'(x); y_in = 7'(y); color_in = 3'(c);
        tick();
        start = 1'b0;
        for (int k = 0; k < W * H; k++) begin
            tick();
            col = k % W; row = k / W;
            ex = x + col; ey = y + row;
            exl = ex[7:0]; eyl = ey[6:0];
            vis = model_plot(col, row, x, y);
            if (vis) exp_plots++;
            if (busy !== 1'b1 || done !== 1'b0 || x_out !== exl || y_out !== eyl ||
                color_out !== 3'(c) || plot !== vis) bad++;
            if (plot === 1'b1) begin
                nplot++;
                if (fx < 0) begin fx = x_out; fy = y_out; end
                lx = x_out; ly = y_out;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                x_in = 8'($urandom); y_in = 7'($urandom); color_in = 3'($urandom);
                if (k == W * H - 1) start = 1'b1;
            end
        end
        tick();
        check("pixel_stream_bad_cycles", bad, 0);
        check("plot_count_vs_model", nplot, exp_plots);
        check("done_after_sweep", int'(done), 1);
        check("busy_low_with_done", int'(busy), 0);
        check("plot_low_at_done", int'(plot), 0);
        start = 1'b0;
    endtask

    initial begin
        int np, fx, fy, lx, ly, stray;

`ifdef PLAYER_SHIP_MASK_EN
        vecs[0] = '{54, 99, 7, 66, 59, 99, 65, 106};
        vecs[1] = '{0, 0, 3, 66, 5, 0, 11, 7};
        vecs[2] = '{250, 0, 5, 0, -1, -1, -1, -1};
        vecs[3] = '{148, 112, 1, 66, 153, 112, 159, 119};
        vecs[4] = '{14, 99, 7, 66, 19, 99, 25, 106};
`else
        vecs[0] = '{14, 99, 7, 96, 14, 99, 25, 106};
        vecs[1] = '{154, 115, 2, 30, 154, 115, 159, 119};
        vecs[2] = '{250, 0, 5, 0, -1, -1, -1, -1};
        vecs[3] = '{148, 112, 1, 96, 148, 112, 159, 119};
        vecs[4] = '{149, 113, 6, 77, 149, 113, 159, 119};
`endif

        reset = 1'b0; start = 1'b1; x_in = 8'd14; y_in = 7'd99; color_in = 3'd7;
        tick(); tick();
        check("reset_x_out", int'(x_out), 0);
        check("reset_y_out", int'(y_out), 0);
        check("reset_color_out", int'(color_out), 0);
        check("reset_plot", int'(plot), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        start = 1'b0; reset = 1'b1;
        tick();
        check("idle_busy_after_reset", int'(busy), 0);

        foreach (vecs[i]) begin
            sweep(vecs[i].x, vecs[i].y, vecs[i].c, 1'b0, np, fx, fy, lx, ly);
            check($sformatf("vec%0d_plots", i), np, vecs[i].plots);
            check($sformatf("vec%0d_first", i), fx * 256 + fy, vecs[i].fx * 256 + vecs[i].fy);
            check($sformatf("vec%0d_last", i), lx * 256 + ly, vecs[i].lx * 256 + vecs[i].ly);
            tick();
        end

        // Back-to-back with start pulses and input churn during the sweep and at the done cycle.
        for (int r = 0; r < 10; r++) begin
            sweep(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 7)), r[0], np, fx, fy, lx, ly);
        end

        start = 1'b1; x_in = 8'd14; y_in = 7'd99; color_in = 3'd7;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check("mid_sweep_plotting", int'(plot), 1);
        check("mid_sweep_x", int'(x_out), 14 + 49 % W);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_x_out", int'(x_out), 0);
        stray = 0;
        repeat (W * H + 4) begin
            tick();
            if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray++;
        end
        check("abort_no_activity", stray, 0);
        sweep(0, 0, 4, 1'b0, np, fx, fy, lx, ly);
        check("fresh_sweep_plots", np, vecs[1].x == 0 ? vecs[1].plots : W * H);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
